// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory port between icache refills and dcache refill/write-back bursts.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default build gives the dcache fixed priority.
module mem_arbiter #(
  parameter int LINE_SIZE = 4,
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ic_req,
  input  logic [31:0]          ic_addr,
  output logic                 ic_grant,
  output logic                 ic_rvalid,
  output logic [WORD_SIZE-1:0] ic_rdata,
  output logic                 ic_done,
  input  logic                 dc_req,
  input  logic                 dc_we,
  input  logic [31:0]          dc_addr,
  input  logic [WORD_SIZE-1:0] dc_wdata,
  output logic                 dc_wnext,
  output logic                 dc_grant,
  output logic                 dc_rvalid,
  output logic [WORD_SIZE-1:0] dc_rdata,
  output logic                 dc_done,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_ready,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam int BEAT_W     = $clog2(LINE_SIZE);
  localparam int WORD_BYTES = WORD_SIZE / 8;
  localparam int LINE_BYTES = LINE_SIZE * WORD_BYTES;
  localparam logic [31:0]       LINE_MASK = ~(32'(LINE_BYTES) - 32'd1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    IC_BURST,
    DC_BURST,
    DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [BEAT_W-1:0] beat_reg, beat_next;
  logic [31:0]       base_reg, base_next;
  logic              we_reg, we_next;
  // Requester encoding for owner/last_grant: 0 = icache, 1 = dcache.
  logic              owner_reg, owner_next;
  logic              last_grant_reg, last_grant_next;

  logic              pick_dc;
  logic              burst_active;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      beat_reg       <= '0;
      base_reg       <= '0;
      we_reg         <= 1'b0;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      beat_reg       <= beat_next;
      base_reg       <= base_next;
      we_reg         <= we_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    pick_dc = dc_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie the requester that did not finish last goes first.
    if (ic_req && dc_req) begin
      pick_dc = ~last_grant_reg;
    end
`endif
  end

  always_comb begin
    state_next      = state_reg;
    beat_next       = beat_reg;
    base_next       = base_reg;
    we_next         = we_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (ic_req || dc_req) begin
          owner_next = pick_dc;
          base_next  = (pick_dc ? dc_addr : ic_addr) & LINE_MASK;
          we_next    = pick_dc & dc_we;
          beat_next  = '0;
          state_next = pick_dc ? DC_BURST : IC_BURST;
        end
      end
      IC_BURST, DC_BURST: begin
        if (mem_ready) begin
          if (beat_reg == LAST_BEAT) begin
            beat_next  = '0;
            state_next = DONE;
          end else begin
            beat_next = beat_reg + BEAT_W'(1);
          end
        end
      end
      DONE: begin
        last_grant_next = owner_reg;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign burst_active = (state_reg == IC_BURST) || (state_reg == DC_BURST);

  always_comb begin
    mem_req   = burst_active;
    mem_we    = (state_reg == DC_BURST) && we_reg;
    mem_addr  = '0;
    mem_wdata = '0;
    if (burst_active) begin
      mem_addr = base_reg + 32'(beat_reg) * 32'(WORD_BYTES);
    end
    if (mem_we) begin
      mem_wdata = dc_wdata;
    end
  end

  logic [1:0]           grant_vec;
  logic [1:0]           rvalid_vec;
  logic [1:0]           done_vec;
  logic [WORD_SIZE-1:0] rdata_arr [2];

  // Per-requester strobes; index 0 is the icache, 1 the dcache.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      localparam state_t OWN_BURST = (gi == 0) ? IC_BURST : DC_BURST;
      assign grant_vec[gi]  = (state_reg == OWN_BURST);
      assign rvalid_vec[gi] = grant_vec[gi] && mem_ready && !we_reg;
      assign done_vec[gi]   = (state_reg == DONE) && (owner_reg == 1'(gi));
      assign rdata_arr[gi]  = rvalid_vec[gi] ? mem_rdata : '0;
    end
  endgenerate

  assign ic_grant  = grant_vec[0];
  assign ic_rvalid = rvalid_vec[0];
  assign ic_rdata  = rdata_arr[0];
  assign ic_done   = done_vec[0];
  assign dc_grant  = grant_vec[1];
  assign dc_rvalid = rvalid_vec[1];
  assign dc_rdata  = rdata_arr[1];
  assign dc_done   = done_vec[1];
  assign dc_wnext  = grant_vec[1] && we_reg && mem_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected beats are queued when a request is issued and
// checked against every memory handshake.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_grant, ic_rvalid, ic_done;
  logic [31:0] ic_rdata;
  logic        dc_req, dc_we;
  logic [31:0] dc_addr, dc_wdata;
  logic        dc_wnext, dc_grant, dc_rvalid, dc_done;
  logic [31:0] dc_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    logic        is_ic;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    hs_count = 0;
  int    wnext_count = 0;
  int    last_hs_cyc = 0;
  int    ready_mode = 0;  // 0: always ready, 1: toggling, 2: never ready
  logic  model_last_dc = 1'b1;

  mem_arbiter #(.LINE_SIZE(4), .WORD_SIZE(32)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_grant(ic_grant), .ic_rvalid(ic_rvalid),
    .ic_rdata(ic_rdata), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wnext(dc_wnext), .dc_grant(dc_grant), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .dc_done(dc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_burst(input logic is_ic, input logic we, input logic [31:0] base,
                            input logic [31:0] data0);
    beat_t e;
    for (int b = 0; b < 4; b++) begin
      e.is_ic = is_ic;
      e.we    = we;
      e.addr  = base + 32'(b * 4);
      e.data  = data0 + 32'(b);
      exp_q.push_back(e);
    end
    hs_count    = 0;
    wnext_count = 0;
  endtask

  // One clock: memory/dcache models drive inputs, then any handshake is scored.
  task automatic tick();
    beat_t e;
    @(negedge clk);
    cyc++;
    mem_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? cyc[0] : 1'b0;
    mem_rdata = 32'hA0 + 32'(hs_count);
    dc_wdata  = 32'hD0 + 32'(wnext_count);
    #1;
    checks++;
    if (ic_grant && dc_grant) begin
      errors++;
      $display("FAIL grant_exclusive: ic_grant=%0b dc_grant=%0b, required not both", ic_grant, dc_grant);
    end
    checks++;
    if (mem_req && mem_ready) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: mem_addr=%h with empty scoreboard", mem_addr);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_we !== e.we) begin
          errors++;
          $display("FAIL beat_addr: addr=%h we=%0b, required addr=%h we=%0b", mem_addr, mem_we, e.addr, e.we);
        end else if (e.we && (dc_wnext !== 1'b1 || mem_wdata !== e.data || dc_rvalid !== 1'b0)) begin
          errors++;
          $display("FAIL write_beat: wnext=%0b wdata=%h, required wnext=1 wdata=%h", dc_wnext, mem_wdata, e.data);
        end else if (!e.we && e.is_ic && (ic_rvalid !== 1'b1 || ic_rdata !== e.data ||
                                          dc_rvalid !== 1'b0 || dc_rdata !== 32'h0)) begin
          errors++;
          $display("FAIL ic_read_beat: rvalid=%0b rdata=%h dc_rdata=%h, required rvalid=1 rdata=%h dc_rdata=0",
                   ic_rvalid, ic_rdata, dc_rdata, e.data);
        end else if (!e.we && !e.is_ic && (dc_rvalid !== 1'b1 || dc_rdata !== e.data ||
                                           ic_rvalid !== 1'b0 || ic_rdata !== 32'h0 || dc_wnext !== 1'b0)) begin
          errors++;
          $display("FAIL dc_read_beat: rvalid=%0b rdata=%h ic_rdata=%h, required rvalid=1 rdata=%h ic_rdata=0",
                   dc_rvalid, dc_rdata, ic_rdata, e.data);
        end
      end
      if (dc_wnext) wnext_count++;
      hs_count++;
      last_hs_cyc = cyc;
      $display("beat %0d: addr=%h we=%0b cyc=%0d", hs_count - 1, mem_addr, mem_we, cyc);
    end else if ((ic_rvalid | dc_rvalid | dc_wnext) !== 1'b0) begin
      errors++;
      $display("FAIL idle_strobe: ic_rvalid=%0b dc_rvalid=%0b dc_wnext=%0b, required 0",
               ic_rvalid, dc_rvalid, dc_wnext);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ready_mode = 0;
    model_last_dc = 1'b1;
    exp_q.delete();
    repeat (3) tick();
    checks++;
    if ({ic_grant, dc_grant, mem_req, mem_we, ic_done, dc_done, ic_rvalid, dc_rvalid, dc_wnext} !== 9'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || ic_rdata !== 32'h0 || dc_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: grants=%0b%0b mem_req=%0b addr=%h wdata=%h, required all 0",
               ic_grant, dc_grant, mem_req, mem_addr, mem_wdata);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (mem_req !== 1'b0 || ic_grant !== 1'b0 || dc_grant !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: mem_req=%0b, required 0", mem_req);
    end
    $display("test_reset done");
  endtask

  task automatic test_ic_refill(input logic [31:0] addr, input logic [31:0] base);
    bit got = 0;
    ready_mode = 0;
    push_burst(1'b1, 1'b0, base, 32'hA0);
    ic_req = 1'b1;
    ic_addr = addr;
    #1;
    checks++;
    if (ic_grant !== 1'b0) begin
      errors++;
      $display("FAIL grant_registered: ic_grant=%0b before edge, required 0", ic_grant);
    end
    tick();
    checks++;
    if (ic_grant !== 1'b1 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL ic_grant_rise: ic_grant=%0b mem_req=%0b, required 1 1", ic_grant, mem_req);
    end
    ic_req = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (ic_done) got = 1;
    end
    checks++;
    if (!got || exp_q.size() != 0 || hs_count != 4 || cyc != last_hs_cyc + 1 ||
        mem_req !== 1'b0 || ic_grant !== 1'b0 || dc_done !== 1'b0) begin
      errors++;
      $display("FAIL ic_done: done=%0b beats=%0d left=%0d gap=%0d mem_req=%0b, required 1 4 0 1 0",
               got, hs_count, exp_q.size(), cyc - last_hs_cyc, mem_req);
    end
    model_last_dc = 1'b0;
    tick();
    checks++;
    if (ic_done !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: ic_done=%0b mem_req=%0b after done, required 0 0", ic_done, mem_req);
    end
    $display("test_ic_refill addr=%h done", addr);
  endtask

  task automatic test_dc_write();
    bit got = 0;
    ready_mode = 1;
    push_burst(1'b0, 1'b1, 32'h20, 32'hD0);
    dc_req = 1'b1;
    dc_we = 1'b1;
    dc_addr = 32'h20;
    tick();
    checks++;
    if (dc_grant !== 1'b1 || mem_we !== 1'b1 || ic_grant !== 1'b0) begin
      errors++;
      $display("FAIL dc_grant_rise: dc_grant=%0b mem_we=%0b, required 1 1", dc_grant, mem_we);
    end
    dc_req = 1'b0;
    dc_we = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (dc_grant) begin
        checks++;
        if (mem_we !== 1'b1) begin
          errors++;
          $display("FAIL mem_we_held: mem_we=%0b at cyc %0d, required 1", mem_we, cyc);
        end
      end
      if (dc_done) got = 1;
    end
    checks++;
    if (!got || exp_q.size() != 0 || wnext_count != 4 || cyc != last_hs_cyc + 1) begin
      errors++;
      $display("FAIL dc_write_done: done=%0b wnext=%0d left=%0d, required 1 4 0", got, wnext_count, exp_q.size());
    end
    model_last_dc = 1'b1;
    tick();
    $display("test_dc_write done");
  endtask

  task automatic test_tie();
    logic win_ic;
    test_reset();
    for (int r = 0; r < 2; r++) begin
      bit got = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      win_ic = model_last_dc;
`else
      win_ic = 1'b0;
`endif
      push_burst(win_ic, 1'b0, win_ic ? 32'h40 : 32'h80, 32'hA0);
      ic_req = 1'b1;
      dc_req = 1'b1;
      dc_we = 1'b0;
      ic_addr = 32'h44;
      dc_addr = 32'h88;
      tick();
      checks++;
      if (ic_grant !== win_ic || dc_grant !== !win_ic) begin
        errors++;
        $display("FAIL tie_grant round %0d: ic=%0b dc=%0b, required ic=%0b dc=%0b",
                 r, ic_grant, dc_grant, win_ic, !win_ic);
      end
      ic_req = 1'b0;
      dc_req = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        tick();
        if (ic_done || dc_done) got = 1;
      end
      checks++;
      if (!got || ic_done !== win_ic || dc_done !== !win_ic || exp_q.size() != 0) begin
        errors++;
        $display("FAIL tie_done round %0d: ic_done=%0b dc_done=%0b left=%0d, required ic_done=%0b left=0",
                 r, ic_done, dc_done, exp_q.size(), win_ic);
      end
      model_last_dc = !win_ic;
      tick();
      $display("test_tie round %0d winner=%s", r, win_ic ? "ic" : "dc");
    end
  endtask

  task automatic test_ic_drop();
    bit got = 0;
    ready_mode = 1;
    push_burst(1'b1, 1'b0, 32'h100, 32'hA0);
    ic_req = 1'b1;
    ic_addr = 32'h108;
    for (int i = 0; i < 20 && hs_count < 2; i++) tick();
    ic_req = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (ic_done) got = 1;
    end
    checks++;
    if (!got || hs_count != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ic_drop: done=%0b beats=%0d, required 1 4", got, hs_count);
    end
    model_last_dc = 1'b0;
    tick();
    $display("test_ic_drop done");
  endtask

  task automatic test_reset_mid();
    bit got = 0;
    ready_mode = 0;
    push_burst(1'b1, 1'b0, 32'h200, 32'hA0);
    ic_req = 1'b1;
    ic_addr = 32'h200;
    tick();
    ic_req = 1'b0;
    tick();
    ready_mode = 2;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h208) begin
      errors++;
      $display("FAIL stall_beat2: mem_req=%0b addr=%h, required 1 00000208", mem_req, mem_addr);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({ic_grant, dc_grant, mem_req, mem_we, ic_done, dc_done, ic_rvalid, dc_rvalid, dc_wnext} !== 9'b0 ||
        mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_burst: grant=%0b mem_req=%0b addr=%h done=%0b, required all 0",
               ic_grant, mem_req, mem_addr, ic_done);
    end
    exp_q.delete();
    model_last_dc = 1'b1;
    tick();
    reset = 1'b1;
    ready_mode = 0;
    tick();
    checks++;
    if (ic_done !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL no_done_after_reset: ic_done=%0b mem_req=%0b, required 0 0", ic_done, mem_req);
    end
    push_burst(1'b1, 1'b0, 32'h200, 32'hA0);
    ic_req = 1'b1;
    ic_addr = 32'h204;
    tick();
    ic_req = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (ic_done) got = 1;
    end
    checks++;
    if (!got || hs_count != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart_after_reset: done=%0b beats=%0d, required 1 4", got, hs_count);
    end
    tick();
    $display("test_reset_mid done");
  endtask

  initial begin
    reset = 1'b0;
    ic_req = 1'b0;
    ic_addr = 32'h0;
    dc_req = 1'b0;
    dc_we = 1'b0;
    dc_addr = 32'h0;
    dc_wdata = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    test_reset();
    test_ic_refill(32'h0000_0014, 32'h0000_0010);
    test_dc_write();
    test_tie();
    test_ic_drop();
    test_reset_mid();
    test_ic_refill(32'hFFFF_FFF4, 32'hFFFF_FFF0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
